// File: rtl/writeback_regfile.sv
// Writeback latch plus 16-entry register file with two bypassed combinational read ports.
// Also keeps a written-since-reset mask and a wrapping commit counter.
module writeback_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    s2,
  input  logic                 wer,
  input  logic [ADDR_W-1:0]    rdestrr,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  output logic [DATA_W-1:0]    rdo1,
  output logic [DATA_W-1:0]    rdo2,
  output logic                 wbwe,
  output logic [ADDR_W-1:0]    wbdest,
  output logic [DATA_W-1:0]    wbdata,
  output logic [2**ADDR_W-1:0] wmask,
  output logic [15:0]          wcnt
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_wbwe;
  logic [ADDR_W-1:0] r_wbdest;
  logic [DATA_W-1:0] r_wbdata;
  logic [NREGS-1:0]  r_wmask;
  logic [15:0]       r_wcnt;

  // Latch loads unconditionally; a result caught in the latch at reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbwe   <= 1'b0;
      r_wbdest <= '0;
      r_wbdata <= '0;
    end else begin
      r_wbwe   <= wer;
      r_wbdest <= rdestrr;
      r_wbdata <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wmask <= '0;
      r_wcnt  <= '0;
    end else if (r_wbwe) begin
      r_regs[r_wbdest]  <= r_wbdata;
      r_wmask[r_wbdest] <= 1'b1;
      r_wcnt            <= r_wcnt + 16'd1;
    end
  end

  // Youngest value wins: execution result, then writeback latch, then the array.
  always_comb begin
    rdo1 = r_regs[rs1];
    if (r_wbwe && (r_wbdest == rs1)) rdo1 = r_wbdata;
    if (wer && (rdestrr == rs1)) rdo1 = s2;
    if (rst) rdo1 = '0;
  end

  always_comb begin
    rdo2 = r_regs[rs2];
    if (r_wbwe && (r_wbdest == rs2)) rdo2 = r_wbdata;
    if (wer && (rdestrr == rs2)) rdo2 = s2;
    if (rst) rdo2 = '0;
  end

  assign wbwe   = r_wbwe;
  assign wbdest = r_wbdest;
  assign wbdata = r_wbdata;
  assign wmask  = r_wmask;
  assign wcnt   = r_wcnt;

endmodule
